// File: rtl/kbd_scan_decoder_pkg.sv
// Shared constants for the PS/2 set-2 scancode decoder: scancode bytes,
// prefix-state encoding and the default FIFO depth.
package kbd_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERR1   = 8'hFF;

    localparam int unsigned KBD_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kbd_state_e;

    // Keyboard/protocol control bytes: never produce output, always return to IDLE.
    function automatic logic is_ctrl(input logic [7:0] b);
        return (b == SC_BAT) || (b == SC_ACK) || (b == SC_RESEND) ||
               (b == SC_ECHO) || (b == SC_ERR0) || (b == SC_ERR1);
    endfunction

endpackage

// File: rtl/kbd_scan_decoder_rom.sv
// Combinational set-2 make-code to US-layout ASCII table.
module kbd_ascii_rom (
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       caps,
    input  logic       ext,
    output logic [7:0] ascii,
    output logic       valid
);

    logic [7:0]  lc;
    logic [15:0] sym;
    logic [7:0]  fix;

    always_comb begin
        lc = '0;
        unique case (code)
            8'h1C: lc = 8'h61;  8'h32: lc = 8'h62;  8'h21: lc = 8'h63;
            8'h23: lc = 8'h64;  8'h24: lc = 8'h65;  8'h2B: lc = 8'h66;
            8'h34: lc = 8'h67;  8'h33: lc = 8'h68;  8'h43: lc = 8'h69;
            8'h3B: lc = 8'h6A;  8'h42: lc = 8'h6B;  8'h4B: lc = 8'h6C;
            8'h3A: lc = 8'h6D;  8'h31: lc = 8'h6E;  8'h44: lc = 8'h6F;
            8'h4D: lc = 8'h70;  8'h15: lc = 8'h71;  8'h2D: lc = 8'h72;
            8'h1B: lc = 8'h73;  8'h2C: lc = 8'h74;  8'h3C: lc = 8'h75;
            8'h2A: lc = 8'h76;  8'h1D: lc = 8'h77;  8'h22: lc = 8'h78;
            8'h35: lc = 8'h79;  8'h1A: lc = 8'h7A;
            default: lc = '0;
        endcase
    end

    // {unshifted, shifted} glyph pairs; caps does not affect these.
    always_comb begin
        sym = '0;
        unique case (code)
            8'h16: sym = 16'h3121;  8'h1E: sym = 16'h3240;  8'h26: sym = 16'h3323;
            8'h25: sym = 16'h3424;  8'h2E: sym = 16'h3525;  8'h36: sym = 16'h365E;
            8'h3D: sym = 16'h3726;  8'h3E: sym = 16'h382A;  8'h46: sym = 16'h3928;
            8'h45: sym = 16'h3029;  8'h0E: sym = 16'h607E;  8'h4E: sym = 16'h2D5F;
            8'h55: sym = 16'h3D2B;  8'h54: sym = 16'h5B7B;  8'h5B: sym = 16'h5D7D;
            8'h5D: sym = 16'h5C7C;  8'h4C: sym = 16'h3B3A;  8'h52: sym = 16'h2722;
            8'h41: sym = 16'h2C3C;  8'h49: sym = 16'h2E3E;  8'h4A: sym = 16'h2F3F;
            default: sym = '0;
        endcase
    end

    always_comb begin
        fix = '0;
        unique case (code)
            8'h29: fix = 8'h20;
            8'h5A: fix = 8'h0D;
            8'h66: fix = 8'h08;
            8'h0D: fix = 8'h09;
            8'h76: fix = 8'h1B;
            default: fix = '0;
        endcase
    end

    always_comb begin
        ascii = '0;
        valid = 1'b0;
        if (ext) begin
            if (code == 8'h4A) begin
                ascii = 8'h2F;
                valid = 1'b1;
            end else if (code == 8'h5A) begin
                ascii = 8'h0D;
                valid = 1'b1;
            end
        end else if (lc != '0) begin
            ascii = (shift ^ caps) ? (lc - 8'h20) : lc;
            valid = 1'b1;
        end else if (sym != '0) begin
            ascii = shift ? sym[7:0] : sym[15:8];
            valid = 1'b1;
        end else if (fix != '0) begin
            ascii = fix;
            valid = 1'b1;
        end
    end

endmodule

// File: rtl/kbd_scan_decoder.sv
// PS/2 set-2 scancode decoder: prefix FSM, modifier tracking, ASCII
// translation and a first-word fall-through output FIFO.
module kbd_scan_decoder
    import kbd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = KBD_FIFO_DEPTH,
    parameter int unsigned PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kbd_rda,
    input  logic [7:0] kbd_databus,
    output logic       ascii_rdy,
    output logic [7:0] ascii_data,
    input  logic       ascii_ack,
    output logic       overflow,
    output logic       caps_on
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    kbd_state_e state_q, state_d;
    logic       make_s, brk_s, ext_s;
    logic       shift_l_q, shift_r_q, caps_q;
    logic [7:0] rom_ascii;
    logic       rom_valid;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             overflow_q;
    logic             push, pop, full, wr_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (kbd_rda) begin
            if (is_ctrl(kbd_databus)) begin
                state_d = ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_IDLE:
                        if (kbd_databus == SC_BREAK)    state_d = ST_BRK;
                        else if (kbd_databus == SC_EXT) state_d = ST_EXT;
                        else                            state_d = ST_IDLE;
                    ST_EXT:
                        state_d = (kbd_databus == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                    default:
                        state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        make_s = 1'b0;
        brk_s  = 1'b0;
        ext_s  = 1'b0;
        if (kbd_rda && !is_ctrl(kbd_databus)) begin
            unique case (state_q)
                ST_IDLE:
                    make_s = (kbd_databus != SC_BREAK) && (kbd_databus != SC_EXT) &&
                             (kbd_databus != SC_PAUSE);
                ST_EXT: begin
                    make_s = (kbd_databus != SC_BREAK);
                    ext_s  = 1'b1;
                end
                ST_BRK:  brk_s = 1'b1;
                default: ;
            endcase
        end
    end

    // Modifiers only react to non-extended codes, so E0-prefixed fake shifts fall through.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_l_q <= 1'b0;
            shift_r_q <= 1'b0;
            caps_q    <= 1'b0;
        end else if (!ext_s) begin
            if (make_s && kbd_databus == SC_LSHIFT) shift_l_q <= 1'b1;
            if (brk_s  && kbd_databus == SC_LSHIFT) shift_l_q <= 1'b0;
            if (make_s && kbd_databus == SC_RSHIFT) shift_r_q <= 1'b1;
            if (brk_s  && kbd_databus == SC_RSHIFT) shift_r_q <= 1'b0;
            if (make_s && kbd_databus == SC_CAPS)   caps_q    <= ~caps_q;
        end
    end

    kbd_ascii_rom u_rom (
        .code  (kbd_databus),
        .shift (shift_l_q | shift_r_q),
        .caps  (caps_q),
        .ext   (ext_s),
        .ascii (rom_ascii),
        .valid (rom_valid)
    );

    assign push  = make_s & rom_valid;
    assign pop   = ascii_ack & (count_q != '0);
    assign full  = (count_q == DEPTH_C);
    assign wr_en = push & (~full | pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= rom_ascii;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_en && !pop)      count_q <= count_q + 1'b1;
            else if (!wr_en && pop) count_q <= count_q - 1'b1;
            if (push && full && !pop) overflow_q <= 1'b1;
        end
    end

    assign ascii_rdy  = (count_q != '0);
    assign ascii_data = mem_q[rd_ptr_q];
    assign overflow   = overflow_q;
    assign caps_on    = caps_q;

endmodule

// File: tb/tb_kbd_scan_decoder.sv
// Directed self-checking bench for kbd_scan_decoder with hand-computed ASCII.
module tb_kbd_scan_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       kbd_rda = 1'b0;
    logic [7:0] kbd_databus = 8'h00;
    logic       ascii_ack = 1'b0;
    logic       ascii_rdy, overflow, caps_on;
    logic [7:0] ascii_data;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    kbd_scan_decoder #(.FIFO_DEPTH(4), .PTR_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .kbd_rda     (kbd_rda),
        .kbd_databus (kbd_databus),
        .ascii_rdy   (ascii_rdy),
        .ascii_data  (ascii_data),
        .ascii_ack   (ascii_ack),
        .overflow    (overflow),
        .caps_on     (caps_on)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Callers sit #1 after a rising edge; returns #1 after the edge that consumed the byte.
    task automatic send(input logic [7:0] b);
        kbd_rda     = 1'b1;
        kbd_databus = b;
        @(posedge clk); #1;
        kbd_rda = 1'b0;
    endtask

    task automatic pop1();
        ascii_ack = 1'b1;
        @(posedge clk); #1;
        ascii_ack = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy",  {7'd0, ascii_rdy}, 8'h00);
        chk("rst_data", ascii_data,        8'h00);
        chk("rst_ovf",  {7'd0, overflow},  8'h00);
        chk("rst_caps", {7'd0, caps_on},   8'h00);
        rst = 1'b1;
        @(posedge clk); #1;

        // a, then its break produces nothing
        send(8'h1C);
        chk("a_rdy_lat", {7'd0, ascii_rdy}, 8'h01);
        chk("a_data",    ascii_data,        8'h61);
        send(8'hF0); send(8'h1C);
        pop1();
        chk("a_single", {7'd0, ascii_rdy}, 8'h00);

        // shift-1 gives '!', release shift then '1'
        send(8'h12); send(8'h16); send(8'hF0); send(8'h16);
        send(8'hF0); send(8'h12); send(8'h16);
        chk("shift_bang", ascii_data, 8'h21); pop1();
        chk("unshift_1",  ascii_data, 8'h31); pop1();
        chk("shift_empty", {7'd0, ascii_rdy}, 8'h00);

        // caps on: 'A'; caps+shift: 'a'
        send(8'h58); send(8'hF0); send(8'h58);
        chk("caps_on", {7'd0, caps_on}, 8'h01);
        send(8'h1C); send(8'h12); send(8'h1C); send(8'hF0); send(8'h12);
        chk("caps_A",      ascii_data, 8'h41); pop1();
        chk("caps_shft_a", ascii_data, 8'h61); pop1();
        send(8'h58);
        chk("caps_off", {7'd0, caps_on}, 8'h00);

        // extended: fake shift ignored, only keypad / and keypad enter map
        send(8'hE0); send(8'h12); send(8'h1C);
        chk("fake_shift", ascii_data, 8'h61); pop1();
        send(8'hE0); send(8'h5A); send(8'hE0); send(8'hF0); send(8'h5A);
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'h4A);
        chk("ext_enter", ascii_data, 8'h0D); pop1();
        chk("ext_slash", ascii_data, 8'h2F); pop1();
        chk("ext_empty", {7'd0, ascii_rdy}, 8'h00);

        // control bytes: no output, FE cancels a pending break
        send(8'hAA); send(8'hFA);
        chk("ctrl_none", {7'd0, ascii_rdy}, 8'h00);
        send(8'hF0); send(8'hFE); send(8'h1C);
        chk("ctrl_brk_cancel", ascii_data, 8'h61); pop1();

        // overflow: a b c d fill, e dropped, f pushed alongside a pop
        send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
        chk("full_no_ovf", {7'd0, overflow}, 8'h00);
        send(8'h24);
        chk("ovf_set",  {7'd0, overflow}, 8'h01);
        chk("ovf_head", ascii_data,       8'h61);
        kbd_rda = 1'b1; kbd_databus = 8'h2B; ascii_ack = 1'b1;
        @(posedge clk); #1;
        kbd_rda = 1'b0; ascii_ack = 1'b0;
        chk("pp_b", ascii_data, 8'h62); pop1();
        chk("pp_c", ascii_data, 8'h63); pop1();
        chk("pp_d", ascii_data, 8'h64); pop1();
        chk("pp_f", ascii_data, 8'h66); pop1();
        chk("pp_empty", {7'd0, ascii_rdy}, 8'h00);

        // async reset mid-cycle clears everything immediately
        send(8'h58); send(8'h1C); send(8'hF0);
        #2 rst = 1'b0;
        #1;
        chk("arst_rdy",  {7'd0, ascii_rdy}, 8'h00);
        chk("arst_ovf",  {7'd0, overflow},  8'h00);
        chk("arst_caps", {7'd0, caps_on},   8'h00);
        chk("arst_data", ascii_data,        8'h00);
        @(posedge clk); #1;
        rst = 1'b1;
        // pending F0 was discarded: 1C is a make
        send(8'h1C);
        chk("arst_prefix", ascii_data, 8'h61);
        chk("arst_prefix_rdy", {7'd0, ascii_rdy}, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
